// File: rtl/arith_fp_pkg.sv
// Shared constants and width helpers for the floating-point operand path.
package arith_fp_pkg;

  localparam int unsigned FP32_W = 32;
  localparam int unsigned FP64_W = 64;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // Count must represent 0..DEPTH inclusive; pointers only 0..DEPTH-1.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return clog2_min1(depth + 1);
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return clog2_min1(depth);
  endfunction

endpackage

// File: rtl/arith_fp_opbuf.sv
// In-order operand buffer with wrapping pointers; DEPTH need not be a power of two.
module arith_fp_opbuf
  import arith_fp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int unsigned CW = cnt_w(DEPTH),
  localparam int unsigned PW = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count
);

  localparam logic [PW-1:0] LP_LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= (r_wr_ptr == LP_LAST) ? '0 : r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= (r_rd_ptr == LP_LAST) ? '0 : r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/arith_fp_operand_join.sv
// Pairs independent A/B operand streams in arrival order and presents them to a subtractor.
module arith_fp_operand_join
  import arith_fp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b
);

  localparam int unsigned   CW       = cnt_w(DEPTH);
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

  if (WIDTH != int'(FP32_W) && WIDTH != int'(FP64_W)) begin : g_bad_width
    $fatal(1, "arith_fp_operand_join: unsupported WIDTH %0d", WIDTH);
  end
  if (DEPTH < 1) begin : g_bad_depth
    $fatal(1, "arith_fp_operand_join: illegal DEPTH %0d", DEPTH);
  end

  logic [CW-1:0]    w_a_count;
  logic [CW-1:0]    w_b_count;
  logic [WIDTH-1:0] w_a_head;
  logic [WIDTH-1:0] w_b_head;
  logic             w_a_push;
  logic             w_b_push;
  logic             w_join;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_a;
  logic [WIDTH-1:0] r_out_b;

  // Ready is derived purely from the registered counts.
  assign a_ready  = (w_a_count < LP_DEPTH);
  assign b_ready  = (w_b_count < LP_DEPTH);
  assign w_a_push = a_valid & a_ready;
  assign w_b_push = b_valid & b_ready;
  assign w_join   = (w_a_count != '0) && (w_b_count != '0) && (!r_out_valid || out_ready);

  arith_fp_opbuf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_buf_a (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_a_push),
    .i_data  (a_data),
    .i_pop   (w_join),
    .o_data  (w_a_head),
    .o_count (w_a_count)
  );

  arith_fp_opbuf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_buf_b (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_b_push),
    .i_data  (b_data),
    .i_pop   (w_join),
    .o_data  (w_b_head),
    .o_count (w_b_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_a     <= '0;
      r_out_b     <= '0;
    end else if (w_join) begin
      r_out_valid <= 1'b1;
      r_out_a     <= w_a_head;
      r_out_b     <= w_b_head;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_a     = r_out_a;
  assign out_b     = r_out_b;

endmodule

// File: tb/tb_arith_fp_operand_join.sv
// Directed checks of the operand join on an f32/DEPTH=2 and an f64/DEPTH=3 instance.
module tb_arith_fp_operand_join;

  logic clk;
  logic rst;

  logic        s_a_valid, s_a_ready, s_b_valid, s_b_ready;
  logic        s_out_valid, s_out_ready;
  logic [31:0] s_a_data, s_b_data, s_out_a, s_out_b;

  logic        d_a_valid, d_a_ready, d_b_valid, d_b_ready;
  logic        d_out_valid, d_out_ready;
  logic [63:0] d_a_data, d_b_data, d_out_a, d_out_b;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] F1 = 32'h3F800000;
  localparam logic [31:0] F2 = 32'h40000000;
  localparam logic [31:0] F3 = 32'h40400000;
  localparam logic [31:0] F4 = 32'h40800000;

  arith_fp_operand_join #(.WIDTH(32), .DEPTH(2)) u_dut32 (
    .clk(clk), .rst(rst),
    .a_valid(s_a_valid), .a_ready(s_a_ready), .a_data(s_a_data),
    .b_valid(s_b_valid), .b_ready(s_b_ready), .b_data(s_b_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_a(s_out_a), .out_b(s_out_b)
  );

  arith_fp_operand_join #(.WIDTH(64), .DEPTH(3)) u_dut64 (
    .clk(clk), .rst(rst),
    .a_valid(d_a_valid), .a_ready(d_a_ready), .a_data(d_a_data),
    .b_valid(d_b_valid), .b_ready(d_b_ready), .b_data(d_b_data),
    .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_a(d_out_a), .out_b(d_out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] va [100];
  logic [63:0] vb [100];

  initial begin
    int ai, bi, oi;
    rst = 1'b1;
    s_a_valid = 0; s_b_valid = 0; s_out_ready = 0; s_a_data = '0; s_b_data = '0;
    d_a_valid = 0; d_b_valid = 0; d_out_ready = 0; d_a_data = '0; d_b_data = '0;
    for (int k = 0; k < 100; k++) begin
      va[k] = {32'(32'h40000000 + k), 32'(32'hA5A50000 + k * 7)};
      vb[k] = {32'(32'hC0000000 + k), 32'(32'h5A5A0000 + k * 3)};
    end
    va[13] = 64'h7FF8000000000000;
    vb[40] = 64'h7FF8000000000000;
    va[55] = 64'h8000000000000000;
    vb[71] = 64'hFFF0000000000000;

    repeat (2) tick();
    rst = 1'b0;
    chk("rst_valid", s_out_valid, 0);
    chk("rst_out_a", s_out_a, 0);
    chk("rst_out_b", s_out_b, 0);
    chk("rst_a_ready", s_a_ready, 1);
    chk("rst_b_ready", s_b_ready, 1);
    chk("rst_valid64", d_out_valid, 0);

    // Single pair into an empty block: visible after the second edge.
    s_out_ready = 1; s_a_valid = 1; s_b_valid = 1; s_a_data = F1; s_b_data = F2;
    tick();
    s_a_valid = 0; s_b_valid = 0;
    chk("t1_lat0", s_out_valid, 0);
    tick();
    chk("t1_valid", s_out_valid, 1);
    chk("t1_out_a", s_out_a, F1);
    chk("t1_out_b", s_out_b, F2);
    tick();
    chk("t1_drain", s_out_valid, 0);

    // A stream runs ahead, fills, back-pressures, then pairs in order.
    s_a_valid = 1; s_a_data = F1;
    chk("t2_a_ready0", s_a_ready, 1);
    tick();
    s_a_data = F2;
    tick();
    s_a_data = F3;
    chk("t2_a_full", s_a_ready, 0);
    chk("t2_b_ready", s_b_ready, 1);
    tick();
    s_b_valid = 1; s_b_data = F1;
    chk("t2_a_held", s_a_ready, 0);
    tick();
    tick();
    s_b_valid = 0;
    chk("t2_p0_valid", s_out_valid, 1);
    chk("t2_p0_a", s_out_a, F1);
    chk("t2_p0_b", s_out_b, F1);
    chk("t2_a_reopen", s_a_ready, 1);
    tick();
    s_a_valid = 0;
    chk("t2_p1_valid", s_out_valid, 1);
    chk("t2_p1_a", s_out_a, F2);
    chk("t2_p1_b", s_out_b, F1);
    tick();
    chk("t2_gap", s_out_valid, 0);
    s_b_valid = 1; s_b_data = F4;
    tick();
    s_b_valid = 0;
    tick();
    chk("t2_p2_valid", s_out_valid, 1);
    chk("t2_p2_a", s_out_a, F3);
    chk("t2_p2_b", s_out_b, F4);
    tick();
    chk("t2_drain", s_out_valid, 0);

    // Output stall: both buffers fill, then drain at one pair per cycle.
    s_out_ready = 0; s_a_valid = 1; s_b_valid = 1;
    s_a_data = 32'h0A00; s_b_data = 32'h0B00;
    tick();
    s_a_data = 32'h0A01; s_b_data = 32'h0B01;
    tick();
    s_a_data = 32'h0A02; s_b_data = 32'h0B02;
    tick();
    s_a_data = 32'h0A03; s_b_data = 32'h0B03;
    chk("t3_a_full", s_a_ready, 0);
    chk("t3_b_full", s_b_ready, 0);
    chk("t3_hold_v", s_out_valid, 1);
    chk("t3_hold_a", s_out_a, 32'h0A00);
    tick();
    chk("t3_hold_a2", s_out_a, 32'h0A00);
    chk("t3_hold_b2", s_out_b, 32'h0B00);
    s_out_ready = 1;
    tick();
    chk("t3_o1_a", s_out_a, 32'h0A01);
    chk("t3_o1_b", s_out_b, 32'h0B01);
    tick();
    s_a_valid = 0; s_b_valid = 0;
    chk("t3_o2_a", s_out_a, 32'h0A02);
    chk("t3_o2_b", s_out_b, 32'h0B02);
    tick();
    chk("t3_o3_v", s_out_valid, 1);
    chk("t3_o3_a", s_out_a, 32'h0A03);
    chk("t3_o3_b", s_out_b, 32'h0B03);
    tick();
    chk("t3_drain", s_out_valid, 0);

    // Reset with full buffers and a held output pair.
    s_out_ready = 0; s_a_valid = 1; s_b_valid = 1;
    s_a_data = 32'h0C00; s_b_data = 32'h0D00;
    repeat (3) tick();
    chk("t4_pre_full", s_a_ready, 0);
    chk("t4_pre_valid", s_out_valid, 1);
    rst = 1;
    tick();
    rst = 0; s_a_valid = 0; s_b_valid = 0; s_out_ready = 1;
    chk("t4_valid", s_out_valid, 0);
    chk("t4_out_a", s_out_a, 0);
    chk("t4_out_b", s_out_b, 0);
    chk("t4_a_ready", s_a_ready, 1);
    chk("t4_b_ready", s_b_ready, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_no_stale", s_out_valid, 0);
    end

    // f64 stream with independent valid/ready patterns and a scoreboard.
    ai = 0; bi = 0; oi = 0;
    for (int cyc = 0; cyc < 3000 && oi < 100; cyc++) begin
      d_a_valid   = (ai < 100) && (cyc % 3 != 1);
      d_b_valid   = (bi < 100) && (cyc % 5 != 2);
      d_a_data    = va[(ai < 100) ? ai : 0];
      d_b_data    = vb[(bi < 100) ? bi : 0];
      d_out_ready = (cyc % 4 != 3);
      if (d_out_valid && d_out_ready) begin
        if (oi < 100) begin
          chk($sformatf("p64_a%0d", oi), d_out_a, va[oi]);
          chk($sformatf("p64_b%0d", oi), d_out_b, vb[oi]);
        end else begin
          chk("p64_extra", 1, 0);
        end
        oi++;
      end
      if (d_a_valid && d_a_ready) ai++;
      if (d_b_valid && d_b_ready) bi++;
      tick();
    end
    d_a_valid = 0; d_b_valid = 0;
    chk("p64_count", oi, 100);
    tick();
    chk("p64_a_empty", d_a_ready, 1);
    chk("p64_b_empty", d_b_ready, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
